// File: rtl/ball_pkg.sv
// Shared constants and state encoding for the bouncing-box motion scheduler.
// Frame geometry lives here so the VGA timing generator and the scheduler agree.
package ball_pkg;

    localparam int FRAME_WIDTH  = 1920;
    localparam int FRAME_HEIGHT = 1080;
    localparam int BOX_WIDTH    = 6;

    localparam int XMAX = FRAME_WIDTH - BOX_WIDTH;
    localparam int YMAX = FRAME_HEIGHT - BOX_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CALC_X,
        ST_CALC_Y,
        ST_COMMIT
    } state_e;

endpackage

// File: rtl/ball_axis_step.sv
// One-axis position step with clamping reflection at 0 and max_pos.
// Arithmetic is one bit wider than the position so pos+step never wraps.
module ball_axis_step #(
    parameter int POS_W  = 12,
    parameter int STEP_W = 4
) (
    input  logic [POS_W-1:0]  pos,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic [POS_W-1:0]  max_pos,
    output logic [POS_W-1:0]  pos_nxt,
    output logic              dir_nxt,
    output logic              bounce
);

    logic [POS_W:0] pos_ext;
    logic [POS_W:0] step_ext;
    logic [POS_W:0] sum;

    always_comb begin
        pos_ext  = {1'b0, pos};
        step_ext = (POS_W+1)'(step);
        sum      = pos_ext + step_ext;
        pos_nxt  = pos;
        dir_nxt  = dir;
        bounce   = 1'b0;
        // dir = 1 moves toward max_pos, dir = 0 toward zero
        if (step != '0) begin
            if (dir) begin
                if (sum >= {1'b0, max_pos}) begin
                    pos_nxt = max_pos;
                    dir_nxt = 1'b0;
                    bounce  = 1'b1;
                end else begin
                    pos_nxt = sum[POS_W-1:0];
                end
            end else begin
                if (pos_ext <= step_ext) begin
                    pos_nxt = '0;
                    dir_nxt = 1'b1;
                    bounce  = 1'b1;
                end else begin
                    pos_nxt = pos - POS_W'(step);
                end
            end
        end
    end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Frame-synchronous box motion scheduler: advances position once every (div+1)
// frame ticks, sharing one axis-step datapath between X and Y.
import ball_pkg::*;

module ball_motion_ctrl #(
    parameter int FRAME_WIDTH  = ball_pkg::FRAME_WIDTH,
    parameter int FRAME_HEIGHT = ball_pkg::FRAME_HEIGHT,
    parameter int BOX_WIDTH    = ball_pkg::BOX_WIDTH,
    parameter int POS_W        = 12,
    parameter int STEP_W       = 4,
    parameter int DIV_W        = 8,
    parameter int X_INIT       = 0,
    parameter int Y_INIT       = 1024
) (
    input  logic              pxl_clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              frame_tick,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [STEP_W-1:0] cfg_dx,
    input  logic [STEP_W-1:0] cfg_dy,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [POS_W-1:0]  box_x,
    output logic [POS_W-1:0]  box_y,
    output logic              bounce_x,
    output logic              bounce_y,
    output logic              busy
);

    localparam logic [POS_W-1:0] X_LIMIT = POS_W'(FRAME_WIDTH - BOX_WIDTH);
    localparam logic [POS_W-1:0] Y_LIMIT = POS_W'(FRAME_HEIGHT - BOX_WIDTH);

    state_e             state_q, state_d;
    logic [POS_W-1:0]   box_x_q, box_x_d, box_y_q, box_y_d;
    logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [STEP_W-1:0]  dx_q, dx_d, dy_q, dy_d;
    logic [DIV_W-1:0]   div_q, div_d, frame_cnt_q, frame_cnt_d;
    logic [POS_W-1:0]   hold_x_q, hold_x_d, hold_y_q, hold_y_d;
    logic               hold_dir_x_q, hold_dir_x_d, hold_dir_y_q, hold_dir_y_d;
    logic               hold_bx_q, hold_bx_d, hold_by_q, hold_by_d;
    logic               bounce_x_q, bounce_x_d, bounce_y_q, bounce_y_d;
    logic               busy_q, busy_d, cfg_ready_q, cfg_ready_d;

    logic               ax_is_y, cfg_fire;
    logic [POS_W-1:0]   ax_pos, ax_max, ax_pos_nxt;
    logic [STEP_W-1:0]  ax_step;
    logic               ax_dir, ax_dir_nxt, ax_bounce;

    // Shared datapath: X during CALC_X, Y during CALC_Y
    assign ax_is_y = (state_q == ST_CALC_Y);
    assign ax_pos  = ax_is_y ? box_y_q : box_x_q;
    assign ax_dir  = ax_is_y ? dir_y_q : dir_x_q;
    assign ax_step = ax_is_y ? dy_q    : dx_q;
    assign ax_max  = ax_is_y ? Y_LIMIT : X_LIMIT;

    ball_axis_step #(
        .POS_W  (POS_W),
        .STEP_W (STEP_W)
    ) u_axis_step (
        .pos     (ax_pos),
        .dir     (ax_dir),
        .step    (ax_step),
        .max_pos (ax_max),
        .pos_nxt (ax_pos_nxt),
        .dir_nxt (ax_dir_nxt),
        .bounce  (ax_bounce)
    );

    assign cfg_fire = cfg_valid & cfg_ready_q;

    always_comb begin
        state_d      = state_q;
        box_x_d      = box_x_q;
        box_y_d      = box_y_q;
        dir_x_d      = dir_x_q;
        dir_y_d      = dir_y_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        div_d        = div_q;
        frame_cnt_d  = frame_cnt_q;
        hold_x_d     = hold_x_q;
        hold_y_d     = hold_y_q;
        hold_dir_x_d = hold_dir_x_q;
        hold_dir_y_d = hold_dir_y_q;
        hold_bx_d    = hold_bx_q;
        hold_by_d    = hold_by_q;
        bounce_x_d   = 1'b0;
        bounce_y_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (frame_tick && !cfg_fire) begin
                    if (frame_cnt_q == div_q) begin
                        frame_cnt_d = '0;
                        state_d     = ST_CALC_X;
                    end else begin
                        frame_cnt_d = frame_cnt_q + DIV_W'(1);
                    end
                end
            end
            ST_CALC_X: begin
                hold_x_d     = ax_pos_nxt;
                hold_dir_x_d = ax_dir_nxt;
                hold_bx_d    = ax_bounce;
                state_d      = ST_CALC_Y;
            end
            ST_CALC_Y: begin
                hold_y_d     = ax_pos_nxt;
                hold_dir_y_d = ax_dir_nxt;
                hold_by_d    = ax_bounce;
                state_d      = ST_COMMIT;
            end
            ST_COMMIT: begin
                box_x_d    = hold_x_q;
                box_y_d    = hold_y_q;
                dir_x_d    = hold_dir_x_q;
                dir_y_d    = hold_dir_y_q;
                bounce_x_d = hold_bx_q;
                bounce_y_d = hold_by_q;
                state_d    = enable ? ST_WAIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // cfg_ready is only high in IDLE/WAIT, so this never lands mid-update
        if (cfg_fire) begin
            dx_d        = cfg_dx;
            dy_d        = cfg_dy;
            div_d       = cfg_div;
            frame_cnt_d = '0;
        end

        busy_d      = (state_d == ST_CALC_X) || (state_d == ST_CALC_Y) || (state_d == ST_COMMIT);
        cfg_ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT);
    end

    always_ff @(posedge pxl_clk) begin
        hold_x_q     <= hold_x_d;
        hold_y_q     <= hold_y_d;
        hold_dir_x_q <= hold_dir_x_d;
        hold_dir_y_q <= hold_dir_y_d;
        hold_bx_q    <= hold_bx_d;
        hold_by_q    <= hold_by_d;
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            box_x_q     <= POS_W'(X_INIT);
            box_y_q     <= POS_W'(Y_INIT);
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            dx_q        <= STEP_W'(1);
            dy_q        <= STEP_W'(1);
            div_q       <= '0;
            frame_cnt_q <= '0;
            bounce_x_q  <= 1'b0;
            bounce_y_q  <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            box_x_q     <= box_x_d;
            box_y_q     <= box_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            div_q       <= div_d;
            frame_cnt_q <= frame_cnt_d;
            bounce_x_q  <= bounce_x_d;
            bounce_y_q  <= bounce_y_d;
            busy_q      <= busy_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign box_x     = box_x_q;
    assign box_y     = box_y_q;
    assign bounce_x  = bounce_x_q;
    assign bounce_y  = bounce_y_q;
    assign busy      = busy_q;
    assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against an update-level model.
module tb_ball_motion_ctrl;

    localparam int POS_W  = 12;
    localparam int STEP_W = 4;
    localparam int DIV_W  = 8;
    localparam int XM     = 1914;
    localparam int YM     = 1074;

    logic              pxl_clk = 1'b0;
    logic              rst_n, enable, frame_tick, cfg_valid;
    logic              cfg_ready;
    logic [STEP_W-1:0] cfg_dx, cfg_dy;
    logic [DIV_W-1:0]  cfg_div;
    logic [POS_W-1:0]  box_x, box_y;
    logic              bounce_x, bounce_y, busy;

    always #5 pxl_clk = ~pxl_clk;

    ball_motion_ctrl #(
        .FRAME_WIDTH (1920), .FRAME_HEIGHT (1080), .BOX_WIDTH (6),
        .POS_W (POS_W), .STEP_W (STEP_W), .DIV_W (DIV_W),
        .X_INIT (0), .Y_INIT (1024)
    ) dut (
        .pxl_clk (pxl_clk), .rst_n (rst_n), .enable (enable), .frame_tick (frame_tick),
        .cfg_valid (cfg_valid), .cfg_ready (cfg_ready), .cfg_dx (cfg_dx), .cfg_dy (cfg_dy),
        .cfg_div (cfg_div), .box_x (box_x), .box_y (box_y), .bounce_x (bounce_x),
        .bounce_y (bounce_y), .busy (busy)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Update-level model: position/direction state, configuration, frame counter,
    // and the number of cycles left until a scheduled update lands.
    int m_x, m_y, m_dx, m_dy, m_div, m_cnt, m_left;
    bit m_dirx, m_diry, m_running, m_bx, m_by, m_ready, m_busy;

    task automatic axis(input int p, input bit d, input int s, input int mx,
                        output int np, output bit nd, output bit b);
        np = p; nd = d; b = 1'b0;
        if (s != 0) begin
            if (d) begin
                if (p + s >= mx) begin np = mx; nd = 1'b0; b = 1'b1; end
                else np = p + s;
            end else begin
                if (p <= s) begin np = 0; nd = 1'b1; b = 1'b1; end
                else np = p - s;
            end
        end
    endtask

    task automatic model_step();
        bit fire;
        int nx, ny;
        bit ndx, ndy, bx, by;
        if (!rst_n) begin
            m_x = 0; m_y = 1024; m_dirx = 1'b1; m_diry = 1'b1;
            m_dx = 1; m_dy = 1; m_div = 0; m_cnt = 0; m_left = 0;
            m_running = 1'b0; m_bx = 1'b0; m_by = 1'b0; m_ready = 1'b0; m_busy = 1'b0;
        end else begin
            fire = cfg_valid && m_ready;
            m_bx = 1'b0; m_by = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    axis(m_x, m_dirx, m_dx, XM, nx, ndx, bx);
                    axis(m_y, m_diry, m_dy, YM, ny, ndy, by);
                    m_x = nx; m_dirx = ndx; m_bx = bx;
                    m_y = ny; m_diry = ndy; m_by = by;
                    m_running = enable;
                end
            end else if (!m_running) begin
                m_running = enable;
            end else if (!enable) begin
                m_running = 1'b0;
            end else if (frame_tick && !fire) begin
                if (m_cnt == m_div) begin m_cnt = 0; m_left = 3; end
                else m_cnt++;
            end
            if (fire) begin
                m_dx = int'(cfg_dx); m_dy = int'(cfg_dy); m_div = int'(cfg_div); m_cnt = 0;
            end
            m_busy  = (m_left > 0);
            m_ready = (m_left == 0);
        end
    endtask

    initial forever begin
        @(posedge pxl_clk);
        model_step();
    end

    initial forever begin
        @(negedge pxl_clk);
        if (cmp_on) begin
            check("box_x", box_x, m_x);
            check("box_y", box_y, m_y);
            check("bounce_x", bounce_x, m_bx);
            check("bounce_y", bounce_y, m_by);
            check("busy", busy, m_busy);
            check("cfg_ready", cfg_ready, m_ready);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge pxl_clk);
    endtask

    // Pulse one tick and return what is visible four cycles later.
    task automatic tick_upd(output int x, output int y, output bit bx, output bit by,
                            output int bcnt);
        frame_tick = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pxl_clk);
            frame_tick = 1'b0;
            if (busy === 1'b1) bcnt++;
        end
        x = int'(box_x); y = int'(box_y); bx = bounce_x; by = bounce_y;
    endtask

    task automatic send_cfg(input int dx, input int dy, input int dv, output int waits);
        cfg_valid = 1'b1;
        cfg_dx = STEP_W'(dx); cfg_dy = STEP_W'(dy); cfg_div = DIV_W'(dv);
        waits = 0;
        while (cfg_ready !== 1'b1 && waits < 20) begin
            @(negedge pxl_clk);
            waits++;
        end
        if (waits >= 20) check("cfg_ready_timeout", waits, 0);
        @(negedge pxl_clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int x, y, bc, w, nbx, nby;
        bit bx, by;

        rst_n = 1'b0; enable = 1'b1; frame_tick = 1'b0; cfg_valid = 1'b0;
        cfg_dx = '0; cfg_dy = '0; cfg_div = '0;
        cyc(3);
        check("rst_box_x", box_x, 0);
        check("rst_box_y", box_y, 1024);
        check("rst_busy", busy, 0);
        check("rst_cfg_ready", cfg_ready, 0);
        rst_n = 1'b1;
        cmp_on = 1'b1;
        cyc(1);
        check("ready_after_release", cfg_ready, 1);

        tick_upd(x, y, bx, by, bc);
        check("first_x", x, 1);
        check("first_y", y, 1025);
        check("first_busy_cycles", bc, 3);
        check("first_no_bounce", {bx, by}, 0);

        for (int i = 2; i <= 51; i++) begin
            tick_upd(x, y, bx, by, bc);
            if (i == 50) begin
                check("ybounce_y", y, 1074);
                check("ybounce_flag", by, 1);
                check("ybounce_x", x, 50);
            end
            if (i == 51) check("yreflect_y", y, 1073);
        end

        rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(1);
        send_cfg(15, 0, 0, w);
        nbx = 0; nby = 0;
        for (int i = 1; i <= 129; i++) begin
            tick_upd(x, y, bx, by, bc);
            nbx += int'(bx); nby += int'(by);
            if (i == 127) check("x_1905", x, 1905);
            if (i == 128) begin check("x_clamp_max", x, 1914); check("x_bounce_max", bx, 1); end
            if (i == 129) check("x_1899", x, 1899);
        end
        for (int i = 1; i <= 128; i++) begin
            tick_upd(x, y, bx, by, bc);
            nbx += int'(bx); nby += int'(by);
            if (i == 126) check("x_9", x, 9);
            if (i == 127) begin check("x_clamp_zero", x, 0); check("x_bounce_zero", bx, 1); end
            if (i == 128) check("x_15", x, 15);
        end
        check("x_run_bounce_x_count", nbx, 2);
        check("x_run_bounce_y_count", nby, 0);
        check("x_run_y_const", y, 1024);

        send_cfg(1, 1, 3, w);
        for (int i = 1; i <= 4; i++) begin
            tick_upd(x, y, bx, by, bc);
            check("div3_busy_cycles", bc, (i == 4) ? 3 : 0);
        end
        check("div3_x", x, 16);

        send_cfg(2, 2, 0, w);
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        send_cfg(3, 1, 1, w);
        check("cfg_held_waits", w, 3);
        check("cfg_held_x", box_x, 18);
        tick_upd(x, y, bx, by, bc);
        check("cfg_restart_no_upd", bc, 0);
        tick_upd(x, y, bx, by, bc);
        check("cfg_restart_upd", bc, 3);
        check("cfg_restart_x", x, 21);

        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        cyc(1);
        rst_n = 1'b0;
        cyc(1);
        check("midrst_busy", busy, 0);
        check("midrst_bounce", {bounce_x, bounce_y}, 0);
        check("midrst_x", box_x, 0);
        check("midrst_y", box_y, 1024);
        rst_n = 1'b1;
        cyc(1);
        tick_upd(x, y, bx, by, bc);
        check("midrst_after_x", x, 1);
        check("midrst_after_y", y, 1025);

        for (int i = 0; i < 4000; i++) begin
            rst_n      = ($urandom_range(0, 499) != 0);
            enable     = ($urandom_range(0, 19) != 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            cfg_valid  = ($urandom_range(0, 9) == 0);
            cfg_dx     = STEP_W'($urandom_range(0, 15));
            cfg_dy     = STEP_W'($urandom_range(0, 15));
            cfg_div    = DIV_W'($urandom_range(0, 3));
            cyc(1);
        end
        rst_n = 1'b1; enable = 1'b1; frame_tick = 1'b0; cfg_valid = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ball_motion_ctrl.md
# ball_motion_ctrl

Frame-synchronous motion scheduler for the bouncing box. It owns the box position and direction state and advances it once every (div+1) frames, at the start of vertical blanking, so position never changes during active video. It accepts run-time speed and rate configuration over a valid/ready handshake. It time-shares one axis-step datapath between X and Y. The VGA timing generator supplies `frame_tick` and consumes `box_x`/`box_y` for pixel hit testing.

## Interface
- `FRAME_WIDTH`, 1920: active pixels per line
- `FRAME_HEIGHT`, 1080: active lines
- `BOX_WIDTH`, 6: box edge length in pixels
- `POS_W`, 12: position width
- `STEP_W`, 4: per-update step width
- `DIV_W`, 8: frame divider width
- `X_INIT`, 0: reset X position
- `Y_INIT`, 1024: reset Y position
- `pxl_clk`  in  1  pixel clock; the only clock
- `rst_n`  in  1  synchronous, active-low reset
- `enable`  in  1  run/pause; low holds position and frame count
- `frame_tick`  in  1  single-cycle pulse at start of vertical blanking
- `cfg_valid`  in  1  config offer
- `cfg_ready`  out  1  config accept possible
- `cfg_dx`  in  STEP_W  X step per update
- `cfg_dy`  in  STEP_W  Y step per update
- `cfg_div`  in  DIV_W  frames between updates minus 1
- `box_x`  out  POS_W  current box left edge
- `box_y`  out  POS_W  current box top edge
- `bounce_x`  out  1  one-cycle pulse, X reflected this update
- `bounce_y`  out  1  one-cycle pulse, Y reflected this update
- `busy`  out  1  update in progress

## Operation
- Limits: XMAX = FRAME_WIDTH − BOX_WIDTH (1914); YMAX = FRAME_HEIGHT − BOX_WIDTH (1074).
- Reset values:
  - box_x = X_INIT, box_y = Y_INIT
  - both directions positive (+)
  - dx = dy = 1, div = 0, frame_cnt = 0
  - bounce_x = bounce_y = busy = 0, cfg_ready = 0
  - state IDLE
- States:
  - IDLE: enable = 0. Goes to WAIT when enable = 1.
  - WAIT: on frame_tick, if frame_cnt == div, clear frame_cnt and go to CALC_X; otherwise frame_cnt+1. Goes to IDLE when enable = 0.
  - CALC_X: X result into a holding register.
  - CALC_Y: Y result into a holding register.
  - COMMIT: load box_x/box_y together, pulse bounce flags. Then WAIT.
- Axis step (computed in POS_W+1 bits, no wrap):
  - dir +, pos+step ≥ MAX: pos = MAX, dir flips, bounce.
  - dir −, pos ≤ step: pos = 0, dir flips, bounce.
  - Otherwise pos ± step.
  - step = 0: pos and dir unchanged, no bounce.
- Config:
  - cfg_ready = 1 in IDLE and WAIT only.
  - Transfer occurs on cfg_valid & cfg_ready. It loads dx/dy/div and clears frame_cnt; directions and positions are untouched.
  - New values apply from the next update.
  - A frame_tick in the same cycle as an accepted config is ignored for counting.
- frame_tick outside WAIT is ignored. enable falling mid-update does not abort; the FSM finishes COMMIT, then goes to IDLE.
- rst_n low in any state restores reset values on the next edge. A partial update is discarded and no bounce pulse is issued.

## Timing
- Sequence for a tick sampled in WAIT at cycle t with frame_cnt == div:
  - busy = 1 in cycles t+1..t+3
  - new box_x/box_y and bounce pulses visible at t+4
  - cfg_ready = 0 in t+1..t+3
- Outputs are registered. box_x and box_y always change in the same cycle.
- Update rate = one per (div+1) frame_ticks while enabled.

## Structure
- Package `ball_pkg`:
  - state enum
  - FRAME_WIDTH/FRAME_HEIGHT/BOX_WIDTH constants, shared with the timing generator
  - XMAX/YMAX derivation
- Sub-module `ball_axis_step`:
  - combinational; inputs pos, dir, step, max; outputs next pos, next dir, bounce
  - one instance, multiplexed between X (CALC_X) and Y (CALC_Y)

## Test plan
- Reset: hold rst_n low 3 cycles → box_x = 0, box_y = 1024, busy = 0, cfg_ready = 0; cfg_ready = 1 the cycle after release (enable = 1).
- Single tick, defaults: one frame_tick → exactly 4 cycles later (1, 1025), busy high 3 cycles, no bounce.
- Y bounce: 50 ticks → y = 1074 with bounce_y on the 50th; 51st tick → 1073.
- X overshoot/clamp (cfg dx = 15, dy = 0, div = 0):
  - 127 ticks → x = 1905; tick 128 → 1914 with bounce_x; tick 129 → 1899.
  - 126 more ticks → 9; next tick → 0 with bounce_x; next → 15.
  - y constant throughout, bounce_y never asserted.
- Divider and config handshake:
  - cfg_div = 3 → update only on every 4th tick.
  - cfg_valid held during busy → no accept until WAIT, then frame_cnt restarts from 0.
- Reset mid-update: rst_n low during CALC_Y → next cycle reset values, no bounce pulse, next tick after release produces (1, 1025).
